// File: rtl/rs_ff_pkg.sv
// Shared encodings for the action taken by rs_ff lanes on the forbidden R=S=1 input.
package rs_ff_pkg;

  localparam int ILL_HOLD   = 0;
  localparam int ILL_SET    = 1;
  localparam int ILL_RESET  = 2;
  localparam int ILL_TOGGLE = 3;

  function automatic logic illegal_next(input int mode, input logic q);
    case (mode)
      ILL_SET:    illegal_next = 1'b1;
      ILL_RESET:  illegal_next = 1'b0;
      ILL_TOGGLE: illegal_next = ~q;
      default:    illegal_next = q;
    endcase
  endfunction

endpackage

// File: rtl/rs_ff_cell.sv
// One RS lane: state bit plus a registered flag raised for a cycle after R=S=1.
module rs_ff_cell
  import rs_ff_pkg::*;
#(
  parameter int ILLEGAL_MODE = ILL_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic r,
  input  logic s,
  output logic q,
  output logic err
);

  logic q_next;
  logic err_next;

  always_comb begin
    q_next   = q;
    err_next = 1'b0;
    case ({s, r})
      2'b10:   q_next = 1'b1;
      2'b01:   q_next = 1'b0;
      2'b11: begin
        q_next   = illegal_next(ILLEGAL_MODE, q);
        err_next = 1'b1;
      end
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= 1'b0;
      err <= 1'b0;
    end else begin
      q   <= q_next;
      err <= err_next;
    end
  end

endmodule

// File: rtl/rs_ff.sv
// Bank of WIDTH independent clocked RS flip-flops with complementary outputs and illegal-input flags.
module rs_ff
  import rs_ff_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int ILLEGAL_MODE = ILL_HOLD
) (
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] err
);

  if (ILLEGAL_MODE < ILL_HOLD || ILLEGAL_MODE > ILL_TOGGLE) begin : g_bad_mode
    $error("rs_ff: ILLEGAL_MODE %0d is out of range 0..3", ILLEGAL_MODE);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    rs_ff_cell #(
      .ILLEGAL_MODE(ILLEGAL_MODE)
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .r  (R[i]),
      .s  (S[i]),
      .q  (Q[i]),
      .err(err[i])
    );
  end

  // Derived from the stored bit so Q and Qn can never agree.
  assign Qn = ~Q;

endmodule

// File: tb/tb_rs_ff.sv
// Directed bench: four single-lane instances (one per illegal mode) plus a 4-lane hold-mode instance.
module tb_rs_ff;
  import rs_ff_pkg::*;

  logic clk;
  logic rst;
  logic r1, s1;
  logic [3:0] r4, s4;

  logic q_m0, qn_m0, err_m0;
  logic q_m1, qn_m1, err_m1;
  logic q_m2, qn_m2, err_m2;
  logic q_m3, qn_m3, err_m3;
  logic [3:0] q_w, qn_w, err_w;

  int passCount = 0;
  int totalCount = 0;

  rs_ff #(.WIDTH(1), .ILLEGAL_MODE(ILL_HOLD)) dut_m0 (
    .Q(q_m0), .Qn(qn_m0), .R(r1), .S(s1), .clk(clk), .rst(rst), .err(err_m0));
  rs_ff #(.WIDTH(1), .ILLEGAL_MODE(ILL_SET)) dut_m1 (
    .Q(q_m1), .Qn(qn_m1), .R(r1), .S(s1), .clk(clk), .rst(rst), .err(err_m1));
  rs_ff #(.WIDTH(1), .ILLEGAL_MODE(ILL_RESET)) dut_m2 (
    .Q(q_m2), .Qn(qn_m2), .R(r1), .S(s1), .clk(clk), .rst(rst), .err(err_m2));
  rs_ff #(.WIDTH(1), .ILLEGAL_MODE(ILL_TOGGLE)) dut_m3 (
    .Q(q_m3), .Qn(qn_m3), .R(r1), .S(s1), .clk(clk), .rst(rst), .err(err_m3));
  rs_ff #(.WIDTH(4), .ILLEGAL_MODE(ILL_HOLD)) dut_w (
    .Q(q_w), .Qn(qn_w), .R(r4), .S(s4), .clk(clk), .rst(rst), .err(err_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst_v, input logic r_v, input logic s_v,
                               input logic [3:0] r4_v, input logic [3:0] s4_v);
    @(negedge clk);
    rst = rst_v;
    r1  = r_v;
    s1  = s_v;
    r4  = r4_v;
    s4  = s4_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
  endtask

  initial begin
    rst = 1'b0; r1 = 1'b0; s1 = 1'b0; r4 = '0; s4 = '0;

    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111);
    checkOutput("reset_q",    {3'b0, q_m0},   4'b0000);
    checkOutput("reset_qn",   {3'b0, qn_m0},  4'b0001);
    checkOutput("reset_err",  {3'b0, err_m0}, 4'b0000);
    checkOutput("reset_w_q",  q_w,  4'b0000);
    checkOutput("reset_w_qn", qn_w, 4'b1111);

    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    checkOutput("set_q",  {3'b0, q_m0},  4'b0001);
    checkOutput("set_qn", {3'b0, qn_m0}, 4'b0000);

    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkOutput("clr_q",  {3'b0, q_m0},  4'b0000);
    checkOutput("clr_qn", {3'b0, qn_m0}, 4'b0001);

    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    checkOutput("reset_repeat_set_err", {3'b0, err_m0}, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    checkOutput("hold1_q1", {3'b0, q_m0}, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    checkOutput("hold1_q2",  {3'b0, q_m0},   4'b0001);
    checkOutput("hold1_qn",  {3'b0, qn_m0},  4'b0000);
    checkOutput("hold1_err", {3'b0, err_m0}, 4'b0000);

    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    checkOutput("hold0_q",  {3'b0, q_m0},  4'b0000);
    checkOutput("hold0_qn", {3'b0, qn_m0}, 4'b0001);

    // Every mode instance starts the illegal sequence from Q=1.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    checkOutput("ill1_m0_q", {3'b0, q_m0}, 4'b0001);
    checkOutput("ill1_m1_q", {3'b0, q_m1}, 4'b0001);
    checkOutput("ill1_m2_q", {3'b0, q_m2}, 4'b0000);
    checkOutput("ill1_m3_q", {3'b0, q_m3}, 4'b0000);
    checkOutput("ill1_m2_qn", {3'b0, qn_m2}, 4'b0001);
    checkOutput("ill1_err", {err_m3, err_m2, err_m1, err_m0}, 4'b1111);

    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    checkOutput("ill2_m3_q",  {3'b0, q_m3},  4'b0001);
    checkOutput("ill2_m3_qn", {3'b0, qn_m3}, 4'b0000);
    checkOutput("ill2_m2_q",  {3'b0, q_m2},  4'b0000);
    checkOutput("ill2_err", {err_m3, err_m2, err_m1, err_m0}, 4'b1111);

    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    checkOutput("legal_err", {err_m3, err_m2, err_m1, err_m0}, 4'b0000);
    checkOutput("legal_q",   {q_m3, q_m2, q_m1, q_m0},         4'b1011);

    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0101);
    checkOutput("w_preload_q", q_w, 4'b0101);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0110, 4'b1010);
    checkOutput("w_mix_q",   q_w,   4'b1001);
    checkOutput("w_mix_qn",  qn_w,  4'b0110);
    checkOutput("w_mix_err", err_w, 4'b0010);

    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111);
    checkOutput("w_all_set_q",   q_w,   4'b1111);
    checkOutput("w_all_set_err", err_w, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111);
    checkOutput("w_midrst_q",   q_w,   4'b0000);
    checkOutput("w_midrst_qn",  qn_w,  4'b1111);
    checkOutput("w_midrst_err", err_w, 4'b0000);
    checkOutput("midrst_modes_q", {q_m3, q_m2, q_m1, q_m0}, 4'b0000);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
